// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, registered results, one-cycle done.
// Optional feature macro SEQ_DIVIDER_DBZ_EN: finish a divide-by-zero in one edge and flag it on div_by_zero.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N:0]    r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          done_q, done_d;
`ifdef SEQ_DIVIDER_DBZ_EN
    logic          dbz_pend_q, dbz_pend_d;
    logic          dbz_q, dbz_d;
`endif

    logic          accept;
    logic [N:0]    r_shift;
    logic [N:0]    trial;
    logic [N:0]    r_step;
    logic [N-1:0]  q_step;

    // Starts arriving mid-iteration are dropped, not queued.
    assign accept = start && (state_q != RUN);

    // One restoring step on the {R, Q} pair.
    always_comb begin
        r_shift = {r_q[N-1:0], q_q[N-1]};
        trial   = r_shift - {1'b0, d_q};
        r_step  = trial[N] ? r_shift : trial;
        q_step  = {q_q[N-2:0], ~trial[N]};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef SEQ_DIVIDER_DBZ_EN
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = RUN;
                    r_d     = '0;
                    q_d     = dividend;
                    d_d     = divisor;
                    cnt_d   = CW'(N);
`ifdef SEQ_DIVIDER_DBZ_EN
                    dbz_pend_d = (divisor == '0);
`endif
                end
            end
            RUN: begin
`ifdef SEQ_DIVIDER_DBZ_EN
                if (dbz_pend_q) begin
                    // Q still holds the untouched dividend here.
                    state_d    = DONE;
                    quot_d     = '1;
                    rem_d      = q_q;
                    done_d     = 1'b1;
                    dbz_d      = 1'b1;
                    dbz_pend_d = 1'b0;
                end else begin
`endif
                    r_d   = r_step;
                    q_d   = q_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        quot_d  = q_step;
                        rem_d   = r_step[N-1:0];
                        done_d  = 1'b1;
`ifdef SEQ_DIVIDER_DBZ_EN
                        dbz_d   = 1'b0;
`endif
                    end
`ifdef SEQ_DIVIDER_DBZ_EN
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
`endif
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
`ifdef SEQ_DIVIDER_DBZ_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
